// File: rtl/chacha_block.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : chacha_block
// Purpose  : Iterative ChaCha block function. Accepts key/nonce/counter,
//            runs ROUNDS single rounds, QR_LANES quarter rounds per clock,
//            adds the original state back and presents a 512-bit keystream
//            block behind a valid/ready handshake.
// Ports    : Clk        - clock, rising edge
//            Reset      - synchronous active-high reset
//            in_valid   / in_ready  - request handshake (ready only in IDLE)
//            key[255:0] - key words 0..7 (word i = key[32i+31:32i])
//            nonce[95:0]- nonce words 0..2
//            counter    - 32-bit block counter
//            out_valid  / out_ready - result handshake
//            out_block  - keystream, state word i = out_block[32i+31:32i]
//            busy       - high whenever the FSM is not IDLE
// Revision : 1.0 - initial release
// ============================================================================
module chacha_block #(
    parameter int ROUNDS   = 20,
    parameter int QR_LANES = 4
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [255:0] key,
    input  logic [95:0]  nonce,
    input  logic [31:0]  counter,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [511:0] out_block,
    output logic         busy
);

    generate
        if ((ROUNDS < 2) || ((ROUNDS % 2) != 0)) begin : g_bad_rounds
            $error("chacha_block: ROUNDS must be even and >= 2");
        end
        if ((QR_LANES != 1) && (QR_LANES != 2) && (QR_LANES != 4)) begin : g_bad_lanes
            $error("chacha_block: QR_LANES must be 1, 2 or 4");
        end
    endgenerate

    localparam int C_STEPS  = 4 * ROUNDS / QR_LANES;
    localparam int C_SW     = $clog2(C_STEPS + 1);
    localparam int C_PHASES = 8 / QR_LANES;     // ROUND cycles per double round
    localparam logic [C_SW-1:0] C_LAST = C_SW'(C_STEPS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        ADD   = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [C_SW-1:0]   step_q;
    logic [31:0]       work_q [16];
    logic [31:0]       orig_q [16];
    logic [31:0]       init_d [16];
    logic [31:0]       round_d [16];
    logic [511:0]      sum_d;
    logic [511:0]      out_block_q;
    logic              out_valid_q;
    logic              accept;

    function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
        return (v << n) | (v >> (32 - n));
    endfunction

    function automatic logic [127:0] qr(input logic [31:0] a_in, input logic [31:0] b_in,
                                        input logic [31:0] c_in, input logic [31:0] d_in);
        logic [31:0] a, b, c, d;
        a = a_in; b = b_in; c = c_in; d = d_in;
        a = a + b; d = rotl(d ^ a, 16);
        c = c + d; b = rotl(b ^ c, 12);
        a = a + b; d = rotl(d ^ a, 8);
        c = c + d; b = rotl(b ^ c, 7);
        return {a, b, c, d};
    endfunction

    // Initial state: constants "expand 32-byte k", key, counter, nonce.
    always_comb begin
        init_d[0] = 32'h61707865;
        init_d[1] = 32'h3320646e;
        init_d[2] = 32'h79622d32;
        init_d[3] = 32'h6b206574;
        for (int i = 0; i < 8; i++) init_d[4 + i] = key[32*i +: 32];
        init_d[12] = counter;
        for (int j = 0; j < 3; j++) init_d[13 + j] = nonce[32*j +: 32];
    end

    // One ROUND step. Quarter-round slot k (0..7) within the double round:
    // slots 0..3 are columns, 4..7 diagonals. The lanes of one step always
    // touch disjoint words, so they can all read work_q and write round_d.
    always_comb begin
        int          ph;
        int          k;
        int          j;
        logic [3:0]  ia, ib, ic, id;
        logic [127:0] qo;
        round_d = work_q;
        ph = int'(step_q) % C_PHASES;
        k  = 0;
        j  = 0;
        ia = 4'd0; ib = 4'd0; ic = 4'd0; id = 4'd0;
        qo = '0;
        for (int l = 0; l < QR_LANES; l++) begin
            k = ph * QR_LANES + l;
            if (k < 4) begin
                ia = 4'(k);
                ib = 4'(4 + k);
                ic = 4'(8 + k);
                id = 4'(12 + k);
            end else begin
                j  = k - 4;
                ia = 4'(j);
                ib = 4'(4 + ((j + 1) % 4));
                ic = 4'(8 + ((j + 2) % 4));
                id = 4'(12 + ((j + 3) % 4));
            end
            qo = qr(work_q[ia], work_q[ib], work_q[ic], work_q[id]);
            round_d[ia] = qo[127:96];
            round_d[ib] = qo[95:64];
            round_d[ic] = qo[63:32];
            round_d[id] = qo[31:0];
        end
    end

    always_comb begin
        for (int i = 0; i < 16; i++) sum_d[32*i +: 32] = work_q[i] + orig_q[i];
    end

    // FSM: state register
    always_ff @(posedge Clk) begin
        if (Reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // FSM: next state and handshake outputs
    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        busy     = 1'b1;
        accept   = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                accept   = in_valid;
                if (in_valid) state_d = ROUND;
            end
            ROUND: if (step_q == C_LAST) state_d = ADD;
            ADD:   state_d = DONE;
            DONE:  if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath registers
    always_ff @(posedge Clk) begin
        if (Reset) begin
            step_q      <= '0;
            work_q      <= '{default: '0};
            orig_q      <= '{default: '0};
            out_block_q <= '0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        work_q <= init_d;
                        orig_q <= init_d;
                        step_q <= '0;
                    end
                end
                ROUND: begin
                    work_q <= round_d;
                    step_q <= step_q + C_SW'(1);
                end
                ADD: begin
                    out_block_q <= sum_d;
                    out_valid_q <= 1'b1;
                end
                DONE: begin
                    if (out_ready) out_valid_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign out_block = out_block_q;

endmodule
`default_nettype wire

// File: tb/tb_chacha_block.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_chacha_block
// Purpose  : Self-checking bench for chacha_block. Four instances cover the
//            default configuration, QR_LANES=1, QR_LANES=2 and ROUNDS=8.
//            Expected blocks come from a reference ChaCha model and known
//            published vectors; a queue holds expectations until output.
// Revision : 1.0 - initial release
// ============================================================================
module tb_chacha_block;

    logic         clk = 1'b0;
    logic         rst;
    logic [255:0] key;
    logic [95:0]  nonce;
    logic [31:0]  ctr;
    logic         out_ready;
    logic         iv [4];
    logic         ir [4];
    logic         ov [4];
    logic         bz [4];
    logic [511:0] ob [4];

    always #5 clk = ~clk;

    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    chacha_block #(.ROUNDS(20), .QR_LANES(4)) u0 (
        .Clk(clk), .Reset(rst), .in_valid(iv[0]), .in_ready(ir[0]), .key(key), .nonce(nonce),
        .counter(ctr), .out_valid(ov[0]), .out_ready(out_ready), .out_block(ob[0]), .busy(bz[0]));
    chacha_block #(.ROUNDS(20), .QR_LANES(1)) u1 (
        .Clk(clk), .Reset(rst), .in_valid(iv[1]), .in_ready(ir[1]), .key(key), .nonce(nonce),
        .counter(ctr), .out_valid(ov[1]), .out_ready(out_ready), .out_block(ob[1]), .busy(bz[1]));
    chacha_block #(.ROUNDS(20), .QR_LANES(2)) u2 (
        .Clk(clk), .Reset(rst), .in_valid(iv[2]), .in_ready(ir[2]), .key(key), .nonce(nonce),
        .counter(ctr), .out_valid(ov[2]), .out_ready(out_ready), .out_block(ob[2]), .busy(bz[2]));
    chacha_block #(.ROUNDS(8), .QR_LANES(4)) u3 (
        .Clk(clk), .Reset(rst), .in_valid(iv[3]), .in_ready(ir[3]), .key(key), .nonce(nonce),
        .counter(ctr), .out_valid(ov[3]), .out_ready(out_ready), .out_block(ob[3]), .busy(bz[3]));

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        int           unit;
        logic [511:0] blk;
        longint       acc;
        int           lat;
        string        name;
    } sb_t;
    sb_t sb_q[$];

    typedef struct {
        logic [255:0] k;
        logic [95:0]  n;
        logic [31:0]  c;
        bit           has_w;
        logic [31:0]  w0;
        logic [31:0]  w1;
    } vec_t;

    // ---------------- reference model ----------------
    function automatic logic [31:0] m_rotl(input logic [31:0] v, input int n);
        return (v << n) | (v >> (32 - n));
    endfunction

    function automatic logic [127:0] m_qr(input logic [31:0] a0, input logic [31:0] b0,
                                          input logic [31:0] c0, input logic [31:0] d0);
        logic [31:0] a, b, c, d;
        a = a0; b = b0; c = c0; d = d0;
        a += b; d ^= a; d = m_rotl(d, 16);
        c += d; b ^= c; b = m_rotl(b, 12);
        a += b; d ^= a; d = m_rotl(d, 8);
        c += d; b ^= c; b = m_rotl(b, 7);
        return {a, b, c, d};
    endfunction

    function automatic logic [511:0] model(input logic [255:0] k, input logic [95:0] n,
                                           input logic [31:0] c, input int rounds);
        logic [31:0]  s [16];
        logic [31:0]  x [16];
        logic [511:0] r;
        s[0] = 32'h61707865; s[1] = 32'h3320646e; s[2] = 32'h79622d32; s[3] = 32'h6b206574;
        for (int i = 0; i < 8; i++) s[4 + i] = k[32*i +: 32];
        s[12] = c;
        for (int i = 0; i < 3; i++) s[13 + i] = n[32*i +: 32];
        x = s;
        for (int i = 0; i < rounds / 2; i++) begin
            {x[0], x[4], x[8],  x[12]} = m_qr(x[0], x[4], x[8],  x[12]);
            {x[1], x[5], x[9],  x[13]} = m_qr(x[1], x[5], x[9],  x[13]);
            {x[2], x[6], x[10], x[14]} = m_qr(x[2], x[6], x[10], x[14]);
            {x[3], x[7], x[11], x[15]} = m_qr(x[3], x[7], x[11], x[15]);
            {x[0], x[5], x[10], x[15]} = m_qr(x[0], x[5], x[10], x[15]);
            {x[1], x[6], x[11], x[12]} = m_qr(x[1], x[6], x[11], x[12]);
            {x[2], x[7], x[8],  x[13]} = m_qr(x[2], x[7], x[8],  x[13]);
            {x[3], x[4], x[9],  x[14]} = m_qr(x[3], x[4], x[9],  x[14]);
        end
        for (int i = 0; i < 16; i++) r[32*i +: 32] = x[i] + s[i];
        return r;
    endfunction

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input int u, input logic [255:0] k, input logic [95:0] n,
                         input logic [31:0] c, input int rounds, input int lat, input string name);
        sb_t e;
        key = k; nonce = n; ctr = c;
        check({name, " in_ready"}, 512'(ir[u]), 512'(1));
        iv[u] = 1'b1;
        tick;
        iv[u] = 1'b0;
        e.unit = u;
        e.blk  = model(k, n, c, rounds);
        e.acc  = cyc;
        e.lat  = lat;
        e.name = name;
        sb_q.push_back(e);
    endtask

    task automatic collect(output logic [511:0] got);
        sb_t e;
        int  guard;
        e     = sb_q.pop_front();
        guard = 0;
        while (ov[e.unit] !== 1'b1 && guard < 200) begin
            tick;
            guard++;
        end
        check({e.name, " out_valid"}, 512'(ov[e.unit]), 512'(1));
        check({e.name, " latency"}, 512'(cyc - e.acc), 512'(e.lat));
        check({e.name, " block"}, ob[e.unit], e.blk);
        got = ob[e.unit];
    endtask

    task automatic release_out(input int u, input string name);
        out_ready = 1'b1;
        tick;
        check({name, " out_valid drop"}, 512'(ov[u]), 512'(0));
        tick;
        check({name, " in_ready back"}, 512'(ir[u]), 512'(1));
        check({name, " busy clear"}, 512'(bz[u]), 512'(0));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [255:0] rfc_key;
        logic [95:0]  rfc_nonce;
        logic [511:0] got;
        logic [511:0] snap;
        vec_t         tv [4];

        for (int i = 0; i < 32; i++) rfc_key[8*i +: 8] = 8'(i);
        rfc_nonce = {32'h00000000, 32'h4a000000, 32'h09000000};

        tv[0] = '{k: rfc_key, n: rfc_nonce, c: 32'd1, has_w: 1'b1, w0: 32'he4e7f110, w1: 32'h15593bd1};
        tv[1] = '{k: '0, n: '0, c: '0, has_w: 1'b1, w0: 32'hade0b876, w1: 32'h903df1a0};
        tv[2] = '{k: {8{32'hdeadbeef}}, n: {32'h01234567, 32'h89abcdef, 32'hffffffff},
                  c: 32'hffffffff, has_w: 1'b0, w0: '0, w1: '0};
        tv[3] = '{k: {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
                  n: {$urandom, $urandom, $urandom}, c: $urandom, has_w: 1'b0, w0: '0, w1: '0};

        for (int u = 0; u < 4; u++) iv[u] = 1'b0;
        key = '0; nonce = '0; ctr = '0;
        out_ready = 1'b1;
        rst = 1'b1;
        tick;
        tick;
        rst = 1'b0;

        // Reset state
        check("reset in_ready", 512'(ir[0]), 512'(1));
        check("reset busy", 512'(bz[0]), 512'(0));
        check("reset out_valid", 512'(ov[0]), 512'(0));
        check("reset out_block", ob[0], 512'(0));

        // Table of vectors on the default instance
        for (int t = 0; t < 4; t++) begin
            issue(0, tv[t].k, tv[t].n, tv[t].c, 20, 21, $sformatf("vec%0d", t));
            collect(got);
            if (tv[t].has_w) begin
                check($sformatf("vec%0d word0", t), 512'(got[31:0]), 512'(tv[t].w0));
                check($sformatf("vec%0d word1", t), 512'(got[63:32]), 512'(tv[t].w1));
            end
            release_out(0, $sformatf("vec%0d", t));
        end

        // Back-pressure: result held for 10 cycles
        out_ready = 1'b0;
        issue(0, tv[2].k, tv[2].n, 32'd7, 20, 21, "hold");
        collect(snap);
        for (int i = 0; i < 10; i++) begin
            tick;
            check("hold block stable", ob[0], snap);
            check("hold out_valid", 512'(ov[0]), 512'(1));
            check("hold in_ready low", 512'(ir[0]), 512'(0));
        end
        release_out(0, "hold");

        // Second request while busy is ignored; late input changes ignored
        issue(0, rfc_key, rfc_nonce, 32'd1, 20, 21, "busy_ignore");
        key   = {8{32'h55aa55aa}};
        nonce = 96'h1;
        ctr   = 32'd99;
        iv[0] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick;
            check("busy in_ready low", 512'(ir[0]), 512'(0));
        end
        iv[0] = 1'b0;
        collect(got);
        check("busy_ignore word0", 512'(got[31:0]), 512'(32'he4e7f110));
        release_out(0, "busy_ignore");

        // Reset mid-round at accept+7, then a fresh RFC request
        key = rfc_key; nonce = rfc_nonce; ctr = 32'd1;
        iv[0] = 1'b1;
        tick;
        iv[0] = 1'b0;
        repeat (6) tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        check("midreset busy", 512'(bz[0]), 512'(0));
        check("midreset in_ready", 512'(ir[0]), 512'(1));
        check("midreset out_valid", 512'(ov[0]), 512'(0));
        check("midreset out_block", ob[0], 512'(0));
        repeat (25) tick;
        check("midreset no late output", 512'(ov[0]), 512'(0));
        issue(0, rfc_key, rfc_nonce, 32'd1, 20, 21, "after_reset");
        collect(got);
        check("after_reset word1", 512'(got[63:32]), 512'(32'h15593bd1));
        release_out(0, "after_reset");

        // Reset beats accept on the same edge
        iv[0] = 1'b1;
        rst   = 1'b1;
        tick;
        iv[0] = 1'b0;
        rst   = 1'b0;
        check("reset over accept busy", 512'(bz[0]), 512'(0));

        // Lane-count and round-count variants
        issue(1, '0, '0, '0, 20, 81, "lanes1");
        collect(got);
        check("lanes1 word0", 512'(got[31:0]), 512'(32'hade0b876));
        release_out(1, "lanes1");
        issue(2, '0, '0, '0, 20, 41, "lanes2");
        collect(got);
        check("lanes2 word1", 512'(got[63:32]), 512'(32'h903df1a0));
        release_out(2, "lanes2");
        issue(3, rfc_key, rfc_nonce, 32'd1, 8, 9, "rounds8");
        collect(got);
        release_out(3, "rounds8");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/chacha_block.md
CHACHA_BLOCK -- requirements
Module: chacha_block

Interface
REQ-001 Parameter ROUNDS, default 20: number of ChaCha single rounds; SHALL be even and >=2; any other value SHALL fail elaboration.
REQ-002 Parameter QR_LANES, default 4: quarter rounds evaluated per clock; SHALL be 1, 2 or 4; any other value SHALL fail elaboration.
REQ-003 Clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 Reset  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  request carries a valid key/nonce/counter.
REQ-006 in_ready  output  1  block accepts a request this cycle.
REQ-007 key  input  256  key; word i = key[32i+31:32i].
REQ-008 nonce  input  96  nonce; word j = nonce[32j+31:32j].
REQ-009 counter  input  32  block counter.
REQ-010 out_valid  output  1  out_block holds a finished keystream block.
REQ-011 out_ready  input  1  consumer takes out_block this cycle.
REQ-012 out_block  output  512  keystream; state word i = out_block[32i+31:32i].
REQ-013 busy  output  1  high in any state other than IDLE.

Function
REQ-014 The initial state SHALL be: w0..w3 = 0x61707865, 0x3320646e, 0x79622d32, 0x6b206574; w4..w11 = key words 0..7; w12 = counter; w13..w15 = nonce words 0..2.
REQ-015 The FSM SHALL have four states: IDLE, ROUND, ADD and DONE.
REQ-016 in_ready SHALL be 1 only in IDLE. Accept = in_valid & in_ready. On accept, the initial state SHALL be loaded into the working and original registers, and the FSM SHALL go to ROUND.
REQ-017 Quarter-round order per double round: columns (0,4,8,12), (1,5,9,13), (2,6,10,14), (3,7,11,15); then diagonals (0,5,10,15), (1,6,11,12), (2,7,8,13), (3,4,9,14). Each ROUND cycle SHALL apply the next QR_LANES quarter rounds of this order, in parallel, to disjoint words.
REQ-018 Quarter round on (a,b,c,d), all arithmetic mod 2^32, rotations left:
- a+=b; d^=a; d<<<=16
- c+=d; b^=c; b<<<=12
- a+=b; d^=a; d<<<=8
- c+=d; b^=c; b<<<=7
REQ-019 A step counter SHALL count N = 4*ROUNDS/QR_LANES ROUND cycles. After the Nth step the FSM SHALL go to ADD. The counter SHALL clear on accept.
REQ-020 ADD (one cycle) SHALL register out_block word i = working word i + original word i (mod 2^32, carry discarded), set out_valid = 1 and go to DONE.
REQ-021 Latency: out_valid SHALL first be high N+1 cycles after the accept edge (21 for defaults; 81 for QR_LANES=1, ROUNDS=20).
REQ-022 In DONE, out_block and out_valid SHALL hold stable while out_ready = 0.
REQ-023 On out_valid & out_ready, out_valid SHALL drop next cycle and the FSM SHALL return to IDLE. in_ready SHALL be 1 the following cycle; requests are never accepted while busy.
REQ-024 in_valid while not in IDLE SHALL be ignored, with no state change. Input changes after accept SHALL NOT affect the result.
REQ-025 out_ready without out_valid SHALL have no effect.

Reset
REQ-026 With Reset high at a rising edge, in any state including mid-round, the following edge SHALL give:
- FSM = IDLE, step counter = 0
- out_valid = 0, out_block = 0, busy = 0, in_ready = 1
- in-flight work discarded
REQ-027 Reset SHALL take priority over accept and over the output handshake on the same edge.

Verification
REQ-028 RFC 8439 s2.3.2: key = bytes 00..1f (word4 = 0x03020100), nonce words {0x09000000, 0x4a000000, 0x00000000}, counter 1 -> out word0 = 0xe4e7f110, word1 = 0x15593bd1; out_valid at accept+21.
REQ-029 All-zero key, nonce and counter -> word0 = 0xade0b876, word1 = 0x903df1a0. Result SHALL be identical for QR_LANES = 1, 2 and 4, with latencies 81, 41 and 21.
REQ-030 out_ready held 0 for 10 cycles after out_valid -> out_block bit-stable and in_ready = 0 throughout. out_ready = 1 -> next cycle out_valid = 0; cycle after that in_ready = 1.
REQ-031 Second request (different key) driven with in_valid while busy -> ignored; output matches the first request only.
REQ-032 Reset pulsed at accept+7 -> next cycle IDLE, out_valid = 0, out_block = 0. A new RFC request afterwards -> correct vector at the new accept+21.
REQ-033 ROUNDS = 8, QR_LANES = 4 -> out_valid at accept+9. Result matches the software ChaCha8 model.
